// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (common with tapController), command
// op codes, controller states and the IEEE 1149.1 TAP transition function.
package jtag_pkg;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'h0,
      RUN_TEST_IDLE    = 4'h1,
      SELECT_DR_SCAN   = 4'h2,
      CAPTURE_DR       = 4'h3,
      SHIFT_DR         = 4'h4,
      EXIT1_DR         = 4'h5,
      PAUSE_DR         = 4'h6,
      EXIT2_DR         = 4'h7,
      UPDATE_DR        = 4'h8,
      SELECT_IR_SCAN   = 4'h9,
      CAPTURE_IR       = 4'hA,
      SHIFT_IR         = 4'hB,
      EXIT1_IR         = 4'hC,
      PAUSE_IR         = 4'hD,
      EXIT2_IR         = 4'hE,
      UPDATE_IR        = 4'hF
   } tap_state_t;

   typedef enum logic [1:0] {
      OP_TAP_RESET = 2'b00,
      OP_IDLE      = 2'b01,
      OP_SHIFT_IR  = 2'b10,
      OP_SHIFT_DR  = 2'b11
   } jtag_op_t;

   typedef enum logic [2:0] {
      CTL_IDLE      = 3'd0,
      CTL_PREAMBLE  = 3'd1,
      CTL_SHIFT     = 3'd2,
      CTL_POSTAMBLE = 3'd3,
      CTL_DONE      = 3'd4
   } ctl_state_t;

   // TMS bits sent before the shift slots, LSB first, and how many there are
   typedef struct packed {
      logic [5:0] pat;
      logic [2:0] len;
   } hdr_t;

   function automatic tap_state_t tap_next_state(input tap_state_t s, input logic tms);
      tap_state_t n;
      case (s)
         TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          n = TEST_LOGIC_RESET;
      endcase
      return n;
   endfunction

   function automatic hdr_t op_header(input jtag_op_t op);
      hdr_t h;
      case (op)
         OP_TAP_RESET: h = '{pat: 6'b011111, len: 3'd6};
         OP_IDLE:      h = '{pat: 6'b000000, len: 3'd0};
         OP_SHIFT_IR:  h = '{pat: 6'b000011, len: 3'd4};
         OP_SHIFT_DR:  h = '{pat: 6'b000001, len: 3'd3};
         default:      h = '{pat: 6'b000000, len: 3'd0};
      endcase
      return h;
   endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Mirror of the target TAP controller, stepped with the slot's TMS on every TCK rise.
module jtag_tap_tracker
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       TRST,
   input  logic       tck_rise,
   input  logic       tms,
   output tap_state_t state
);

   tap_state_t state_q;
   tap_state_t state_d;

   // next TAP state
   always_comb begin
      if (tck_rise) begin
         state_d = tap_next_state(state_q, tms);
      end else begin
         state_d = state_q;
      end
   end

   // TAP state register
   always_ff @(posedge clk or negedge TRST) begin
      if (!TRST) begin
         state_q <= TEST_LOGIC_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: runs one TAP_RESET / IDLE / SHIFT_IR / SHIFT_DR command at a
// time as a series of TCK slots and returns the TDO bits captured during the shift slots.
module jtag_scan_master
   import jtag_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int DIV     = 2,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               TRST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               TCK,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO
);

   localparam int IDX_W  = (LEN_W > 3) ? LEN_W : 3;
   localparam int CNT_W  = $clog2(2 * DIV + 1);
   localparam int DAT_IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   ctl_state_t         ctl_q, ctl_d;
   jtag_op_t           op_q, op_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [6:0]         pre_pat_q, pre_pat_d;
   logic [2:0]         pre_len_q, pre_len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tck_q, tck_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               cmd_ready_q, cmd_ready_d;

   tap_state_t         tap_state;
   hdr_t               hdr;
   logic               accept;
   logic               pre_needed;
   logic               zero_len;
   logic               slot_end;
   logic               in_slot_d;
   logic               tck_rise;
   logic [LEN_W-1:0]   len_clamp;
   logic [6:0]         acc_pre_pat;
   logic [2:0]         acc_pre_len;
   logic [IDX_W-1:0]   idx_step;
   logic [CNT_W-1:0]   cnt_step;

   assign accept      = cmd_valid & cmd_ready_q;
   assign hdr         = op_header(jtag_op_t'(cmd_op));
   assign len_clamp   = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
   // Out of Test-Logic-Reset every non-reset command first needs one TMS=0 slot
   assign pre_needed  = (tap_state == TEST_LOGIC_RESET) && (cmd_op != OP_TAP_RESET);
   assign acc_pre_pat = pre_needed ? {hdr.pat, 1'b0} : {1'b0, hdr.pat};
   assign acc_pre_len = hdr.len + {2'b00, pre_needed};
   assign zero_len    = (cmd_op != OP_TAP_RESET) && (len_clamp == {LEN_W{1'b0}});
   assign slot_end    = (cnt_q == CNT_W'(2 * DIV - 1));
   assign cnt_step    = slot_end ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
   assign idx_step    = slot_end ? idx_q + IDX_W'(1) : idx_q;

   // controller state register
   always_ff @(posedge clk or negedge TRST) begin
      if (!TRST) begin
         ctl_q <= CTL_IDLE;
      end else begin
         ctl_q <= ctl_d;
      end
   end

   // next controller state, slot position and latched command
   always_comb begin
      ctl_d     = ctl_q;
      op_d      = op_q;
      len_d     = len_q;
      data_d    = data_q;
      pre_pat_d = pre_pat_q;
      pre_len_d = pre_len_q;
      idx_d     = idx_step;
      cnt_d     = cnt_step;
      case (ctl_q)
         CTL_IDLE: begin
            idx_d = {IDX_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            if (accept) begin
               op_d      = jtag_op_t'(cmd_op);
               len_d     = len_clamp;
               data_d    = cmd_data;
               pre_pat_d = acc_pre_pat;
               pre_len_d = acc_pre_len;
               ctl_d     = zero_len ? CTL_DONE :
                           (acc_pre_len != 3'd0) ? CTL_PREAMBLE : CTL_SHIFT;
            end else begin
               ctl_d = CTL_IDLE;
            end
         end
         CTL_PREAMBLE: begin
            if (slot_end && (idx_q == IDX_W'(pre_len_q) - IDX_W'(1))) begin
               idx_d = {IDX_W{1'b0}};
               ctl_d = (op_q == OP_TAP_RESET) ? CTL_DONE : CTL_SHIFT;
            end else begin
               ctl_d = CTL_PREAMBLE;
            end
         end
         CTL_SHIFT: begin
            if (slot_end && (idx_q == IDX_W'(len_q) - IDX_W'(1))) begin
               idx_d = {IDX_W{1'b0}};
               ctl_d = (op_q == OP_IDLE) ? CTL_DONE : CTL_POSTAMBLE;
            end else begin
               ctl_d = CTL_SHIFT;
            end
         end
         CTL_POSTAMBLE: begin
            if (slot_end && (idx_q == IDX_W'(1))) begin
               idx_d = {IDX_W{1'b0}};
               ctl_d = CTL_DONE;
            end else begin
               ctl_d = CTL_POSTAMBLE;
            end
         end
         CTL_DONE: begin
            ctl_d = CTL_IDLE;
         end
         default: begin
            ctl_d = CTL_IDLE;
         end
      endcase
   end

   // pin values for the coming cycle; TMS/TDI are only recomputed per slot
   always_comb begin
      in_slot_d = (ctl_d == CTL_PREAMBLE) || (ctl_d == CTL_SHIFT) || (ctl_d == CTL_POSTAMBLE);
      tck_d     = in_slot_d && (cnt_d >= CNT_W'(DIV));
      tck_rise  = tck_d & ~tck_q;
      tms_d     = tms_q;
      tdi_d     = 1'b0;
      case (ctl_d)
         CTL_PREAMBLE:  tms_d = pre_pat_d[idx_d[2:0]];
         CTL_SHIFT: begin
            tms_d = op_d[1] && (idx_d == IDX_W'(len_d) - IDX_W'(1));
            tdi_d = op_d[1] & data_d[idx_d[DAT_IW-1:0]];
         end
         CTL_POSTAMBLE: tms_d = (idx_d == {IDX_W{1'b0}});
         default:       tms_d = tms_q;
      endcase
      rsp_data_d = rsp_data_q;
      if ((ctl_q == CTL_IDLE) && accept) begin
         rsp_data_d = {MAX_LEN{1'b0}};
      end else if (tck_rise && (ctl_q == CTL_SHIFT) && op_q[1]) begin
         rsp_data_d[idx_q[DAT_IW-1:0]] = TDO;
      end else begin
         rsp_data_d = rsp_data_q;
      end
      rsp_valid_d = (ctl_q == CTL_DONE);
      cmd_ready_d = (ctl_d == CTL_IDLE);
   end

   // datapath and pin registers
   always_ff @(posedge clk or negedge TRST) begin
      if (!TRST) begin
         op_q        <= OP_TAP_RESET;
         len_q       <= {LEN_W{1'b0}};
         data_q      <= {MAX_LEN{1'b0}};
         pre_pat_q   <= 7'd0;
         pre_len_q   <= 3'd0;
         idx_q       <= {IDX_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {MAX_LEN{1'b0}};
         cmd_ready_q <= 1'b1;
      end else begin
         op_q        <= op_d;
         len_q       <= len_d;
         data_q      <= data_d;
         pre_pat_q   <= pre_pat_d;
         pre_len_q   <= pre_len_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   jtag_tap_tracker u_tracker (
      .clk      (clk),
      .TRST     (TRST),
      .tck_rise (tck_rise),
      .tms      (tms_q),
      .state    (tap_state)
   );

   assign cmd_ready = cmd_ready_q;
   assign busy      = ~cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign TCK       = tck_q;
   assign TMS       = tms_q;
   assign TDI       = tdi_q;

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
Host-side JTAG sequencer that drives an external or on-chip TAP controller (tapController) through its 16-state FSM. It accepts one command at a time from a valid/ready port: TAP reset, idle clocks, IR shift or DR shift. It generates TCK, TMS and TDI, samples TDO, and returns the captured scan data. It sits between a debug/CSR front end and the JTAG pins.

Parameters:
MAX_LEN, 32, maximum scan length in bits; width of data buses.
DIV, 2, TCK half-period in clk cycles (>=1); TCK frequency = f_clk / (2*DIV).
LEN_W, $clog2(MAX_LEN+1), width of cmd_len.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
TRST  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  block idle and able to accept a command.
cmd_op  input  2  00 TAP_RESET, 01 IDLE, 10 SHIFT_IR, 11 SHIFT_DR.
cmd_len  input  LEN_W  bit count (SHIFT) or TCK count (IDLE).
cmd_data  input  MAX_LEN  TDI payload, sent LSB first.
rsp_valid  output  1  one-cycle pulse when the command completes.
rsp_data  output  MAX_LEN  captured TDO bits, LSB first; upper bits are 0.
busy  output  1  command in progress (equals ~cmd_ready).
TCK  output  1  generated test clock, idle low.
TMS  output  1  test mode select.
TDI  output  1  test data out to the target.
TDO  input  1  test data in from the target.

Behaviour:
- Reset values (TRST=0, applied asynchronously): TCK=0, TMS=1, TDI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0. The tracked TAP state is TEST_LOGIC_RESET.
- Acceptance: a command is accepted on a clk edge where cmd_valid and cmd_ready are both 1. op, len and data are registered at that edge. cmd_ready=0 from the next cycle until the rsp_valid cycle. cmd_ready returns to 1 in the same cycle that rsp_valid pulses.
- TCK bit slot: DIV clk cycles low, then DIV clk cycles high.
  - TMS and TDI change only at the start of the low phase.
  - TDO is registered on the clk edge that drives TCK high.
  - The tracked state advances using that slot's TMS.
- Controller FSM states: IDLE, PREAMBLE, SHIFT, POSTAMBLE, DONE.
- PREAMBLE rule: if the tracked state is TEST_LOGIC_RESET and op != TAP_RESET, one extra slot with TMS=0 is inserted first, to reach RUN_TEST_IDLE. Otherwise every command starts and ends in RUN_TEST_IDLE.
- Per-op TMS sequences:
  - TAP_RESET: 1,1,1,1,1,0. Six slots, ends in RUN_TEST_IDLE; cmd_len is ignored.
  - IDLE: len slots with TMS=0.
  - SHIFT_DR: 1,0,0, then len shift slots, then 1,0. Shift-slot TMS is 0 except the last, which is 1 (to Exit1). Total len+5 slots.
  - SHIFT_IR: 1,1,0,0, then len shift slots, then 1,0. Total len+6 slots.
- Shift data: during shift slot k (k=0..len-1), TDI=cmd_data[k] and the TDO sample is stored to rsp_data[k]. TDI=0 outside shift slots.
- Length boundaries:
  - len=0 on IDLE/SHIFT: no TCK pulses; rsp_valid 1 cycle after acceptance, rsp_data=0.
  - len>MAX_LEN is clamped to MAX_LEN.
- Completion: rsp_valid pulses in the clk cycle after the last slot's high phase ends (TCK already low). rsp_data holds its value until the next acceptance. IDLE and TAP_RESET return rsp_data=0.
- TRST asserted mid-command: the command is aborted at once and all outputs go to reset values. No rsp_valid is issued. The tracked state becomes TEST_LOGIC_RESET.
- cmd_valid while busy is ignored; there is no queuing.

Decomposition:
- jtag_pkg: tap_state_t (16 states, shared encoding with tapController); op codes; the tap_next_state(state, tms) function.
- Sub-module jtag_tap_tracker: mirrors the TAP FSM from TMS on each TCK rise. It is reset to TEST_LOGIC_RESET and feeds the PREAMBLE decision. TCK divider and slot counters stay in the top module.

Test Plan:
1. TRST=0 for 3 clk, then release -> TCK=0, TMS=1, TDI=0, cmd_ready=1, rsp_valid=0 throughout. No TCK edges until a command is accepted.
2. TAP_RESET, DIV=2 -> 6 TCK pulses, TMS=1,1,1,1,1,0. rsp_valid 25 clk after acceptance. tapController ends in RUN_TEST_IDLE.
3. After step 2: SHIFT_DR, len=8, data=0xA5, target in BYPASS -> 13 TCK pulses; TMS=1,0,0,0,0,0,0,0,0,0,1,1,0; TDI bits 1,0,1,0,0,1,0,1; rsp_data=0x4A.
4. SHIFT_IR, len=4, data=0xF -> 10 TCK pulses, TMS=1,1,0,0,0,0,0,1,1,0. Next command shows no preamble slot.
5. Directly after reset, SHIFT_DR len=8 -> 14 TCK pulses, the first with TMS=0. Also: len=0 -> 0 TCK pulses and rsp_valid 1 cycle after acceptance; len=40 -> shifts 32 bits.
6. TRST pulled low at shift slot 3 of SHIFT_DR len=16 -> TCK=0 and TMS=1 immediately, no rsp_valid. After release, cmd_ready=1 and the next command includes the preamble slot.
